// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg : shared types and constants for the MIPS pipeline      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetchState_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg : stage register with load, bubble insert and async clear  |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] pcIn,
  input  logic [DATA_W-1:0] instrIn,
  output logic [ADDR_W-1:0] pcOut,
  output logic [DATA_W-1:0] instrOut,
  output logic              validOut
);

  // Bubble leaves the PC untouched and always carries a NOP word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcOut    <= '0;
      instrOut <= DATA_W'(NOP_INSTR);
      validOut <= 1'b0;
    end else if (bubble) begin
      instrOut <= DATA_W'(NOP_INSTR);
      validOut <= 1'b0;
    end else if (load) begin
      pcOut    <= pcIn;
      instrOut <= instrIn;
      validOut <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : IF stage + IF/ID register, imem req/ready, hold buffer  |
// | Optional   : FETCH_PERF_EN adds stall_cycles / flush_count counters  |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              flush,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_id,
  output logic [31:0]       instr_id,
  output logic              valid_id
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam logic [ADDR_W-1:0] c_alignMask = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_pcStep    = ADDR_W'(PC_STEP);

  fetchState_t       r_state, w_nextState;
  logic [ADDR_W-1:0] r_pc, w_nextPc, r_drainAddr, r_holdPc;
  logic [31:0]       r_holdInstr;
  logic [ADDR_W-1:0] w_redirect, w_idPc;
  logic [31:0]       w_idInstr;
  logic              w_idLoad, w_idBubble, w_holdLoad;

  assign w_redirect = redirect_pc & c_alignMask;

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_idLoad    = 1'b0;
    w_idBubble  = 1'b0;
    w_idPc      = r_pc;
    w_idInstr   = imem_rdata;
    w_holdLoad  = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = r_pc;
    case (r_state)
      IDLE: begin
        w_nextState = REQ;
        if (flush) begin
          w_nextPc   = w_redirect;
          w_idBubble = 1'b1;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (flush) begin
          w_idBubble  = 1'b1;
          w_nextPc    = w_redirect;
          w_nextState = imem_ready ? REQ : DRAIN;
        end else if (imem_ready) begin
          if (if_id_write) begin
            w_idLoad = 1'b1;
            if (pc_write) w_nextPc = r_pc + c_pcStep;
          end else begin
            w_holdLoad  = 1'b1;
            w_nextState = HOLD;
          end
        end else if (if_id_write) begin
          w_idBubble = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          w_idBubble  = 1'b1;
          w_nextPc    = w_redirect;
          w_nextState = REQ;
        end else if (if_id_write) begin
          w_idLoad    = 1'b1;
          w_idPc      = r_holdPc;
          w_idInstr   = r_holdInstr;
          w_nextState = REQ;
          if (pc_write) w_nextPc = r_pc + c_pcStep;
        end
      end
      DRAIN: begin
        // Keep the stale request alive until memory answers, then drop its data.
        imem_req  = 1'b1;
        imem_addr = r_drainAddr;
        if (flush) begin
          w_idBubble = 1'b1;
          w_nextPc   = w_redirect;
        end
        if (imem_ready) w_nextState = REQ;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pc        <= PC_RESET & c_alignMask;
      r_drainAddr <= '0;
      r_holdPc    <= '0;
      r_holdInstr <= NOP_INSTR;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      if (r_state == REQ) r_drainAddr <= r_pc;
      if (w_holdLoad) begin
        r_holdPc    <= r_pc;
        r_holdInstr <= imem_rdata;
      end
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_ifId (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (w_idLoad),
    .bubble  (w_idBubble),
    .pcIn    (w_idPc),
    .instrIn (w_idInstr),
    .pcOut   (pc_id),
    .instrOut(instr_id),
    .validOut(valid_id)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!if_id_write && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : scoreboard bench for fetch_unit                      |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        pc_write;
  logic        if_id_write;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sbQ[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) + 32'h0000_0101;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  fetch_unit #(
    .ADDR_W  (32),
    .PC_RESET(32'h0000_0000)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc_write   (pc_write),
    .if_id_write(if_id_write),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_id      (pc_id),
    .instr_id   (instr_id),
    .valid_id   (valid_id)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef FETCH_PERF_EN
  logic [31:0] mStall, mFlush;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mStall <= 32'd0;
      mFlush <= 32'd0;
    end else begin
      if (!if_id_write) mStall <= mStall + 32'd1;
      if (flush) mFlush <= mFlush + 32'd1;
    end
  end
`endif

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expectFetch(input logic [31:0] a);
    sbQ.push_back('{1'b1, a, memWord(a)});
  endtask

  task automatic expectBubble();
    sbQ.push_back('{1'b0, 32'h0, 32'h0});
  endtask

  task automatic checkSb(input string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      checkVal({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkVal({tag, "_valid"}, {31'd0, valid_id}, {31'd0, e.v});
      checkVal({tag, "_instr"}, instr_id, e.ins);
      if (e.v) checkVal({tag, "_pc"}, pc_id, e.pc);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush       = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b1;
    #1;
    checkVal("rst_req", {31'd0, imem_req}, 32'd0);
    checkVal("rst_valid", {31'd0, valid_id}, 32'd0);
    checkVal("rst_instr", instr_id, 32'h0);
    checkVal("rst_pc_id", pc_id, 32'h0);

    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checkVal("idle_bubble", {31'd0, valid_id}, 32'd0);
    checkVal("req_after_idle", {31'd0, imem_req}, 32'd1);

    // zero-wait stream
    for (int i = 0; i < 2; i++) begin
      checkVal("zw_addr", imem_addr, 32'(i * 4));
      expectFetch(32'(i * 4));
      tick();
      checkSb("zw");
    end

    // stall while fetch at 8 completes
    checkVal("stall_addr", imem_addr, 32'h8);
    if_id_write = 1'b0;
    pc_write    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkVal("hold_req", {31'd0, imem_req}, 32'd0);
      checkVal("hold_pc", imem_addr, 32'h8);
      checkVal("hold_pc_id", pc_id, 32'h4);
      checkVal("hold_valid", {31'd0, valid_id}, 32'd1);
    end
    if_id_write = 1'b1;
    pc_write    = 1'b1;
    expectFetch(32'h8);
    tick();
    checkSb("release");
    checkVal("release_addr", imem_addr, 32'hC);
    expectFetch(32'hC);
    tick();
    checkSb("zw_c");
    checkVal("addr_10", imem_addr, 32'h10);

    // flush with ready=1; low address bits of the target are ignored
    flush       = 1'b1;
    redirect_pc = 32'h42;
    expectBubble();
    tick();
    flush = 1'b0;
    checkSb("flush_rdy");
    checkVal("flush_rdy_addr", imem_addr, 32'h40);
    expectFetch(32'h40);
    tick();
    checkSb("after_flush");
    checkVal("addr_44", imem_addr, 32'h44);

    // slow memory: not-ready cycle loads a bubble, then flush while pending
    imem_ready = 1'b0;
    expectBubble();
    tick();
    checkSb("wait_bubble");
    checkVal("wait_addr", imem_addr, 32'h44);
    flush       = 1'b1;
    redirect_pc = 32'h80;
    expectBubble();
    tick();
    flush = 1'b0;
    checkSb("flush_wait");
    checkVal("drain_addr", imem_addr, 32'h44);
    checkVal("drain_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    expectBubble();
    tick();
    checkSb("drain_discard");
    checkVal("drain_new_addr", imem_addr, 32'h80);
    expectFetch(32'h80);
    tick();
    checkSb("post_drain");
    checkVal("addr_84", imem_addr, 32'h84);

    // flush beats a simultaneous stall
    flush       = 1'b1;
    if_id_write = 1'b0;
    pc_write    = 1'b0;
    redirect_pc = 32'hFFFF_FFFC;
    expectBubble();
    tick();
    flush       = 1'b0;
    if_id_write = 1'b1;
    pc_write    = 1'b1;
    checkSb("flush_stall");
    checkVal("flush_stall_addr", imem_addr, 32'hFFFF_FFFC);
    checkVal("flush_stall_req", {31'd0, imem_req}, 32'd1);

    // wraparound
    expectFetch(32'hFFFF_FFFC);
    tick();
    checkSb("wrap");
    checkVal("wrap_addr", imem_addr, 32'h0);

    // reset mid-request drops the request without a clock edge
    imem_ready = 1'b0;
    tick();
    checkVal("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkVal("async_rst_req", {31'd0, imem_req}, 32'd0);
    checkVal("async_rst_valid", {31'd0, valid_id}, 32'd0);
    checkVal("async_rst_pc_id", pc_id, 32'h0);
    checkVal("async_rst_instr", instr_id, 32'h0);

    // late ready after release is ignored in IDLE
    imem_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checkVal("late_ready_valid", {31'd0, valid_id}, 32'd0);
    checkVal("late_ready_addr", imem_addr, 32'h0);
    expectFetch(32'h0);
    tick();
    checkSb("restart");

`ifdef FETCH_PERF_EN
    checkVal("stall_cycles", stall_cycles, mStall);
    checkVal("flush_count", flush_count, mFlush);
`endif

    checkVal("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
